// File: rtl/riscv_dmem_resp.sv
// Data-memory responder for the single-cycle riscv_cpu: word RAM with byte/half/word
// stores, extended loads, and an MMIO page holding GPIO, CYCLE and sticky STATUS.
module riscv_dmem_resp #(
    parameter int unsigned DEPTH_WORDS = 64,
    parameter logic [31:0] MMIO_BASE   = 32'h0000_1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic        MemRead,
    input  logic [2:0]  funct3,
    input  logic [31:0] Mem_WrAddr,
    input  logic [31:0] Mem_WrData,
    output logic [31:0] ReadData,
    output logic [31:0] gpio_out,
    output logic        err_irq
);

    localparam int unsigned AW     = $clog2(DEPTH_WORDS);
    localparam logic [29:0] BASE_W = MMIO_BASE[31:2];

    typedef enum logic [1:0] {
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD,
        SZ_ILL
    } size_e;

    typedef enum logic [2:0] {
        RG_RAM,
        RG_GPIO,
        RG_CYCLE,
        RG_STATUS,
        RG_NONE
    } region_e;

    function automatic logic [31:0] extend_load(input logic [31:0] lane,
                                                input size_e       sz,
                                                input logic        sx);
        logic [31:0] res;
        case (sz)
            SZ_BYTE: res = {{24{sx & lane[7]}}, lane[7:0]};
            SZ_HALF: res = {{16{sx & lane[15]}}, lane[15:0]};
            SZ_WORD: res = lane;
            default: res = 32'd0;
        endcase
        return res;
    endfunction

    function automatic logic [3:0] lane_mask(input size_e sz, input logic [1:0] off);
        logic [3:0] m;
        case (sz)
            SZ_BYTE: m = 4'b0001 << off;
            SZ_HALF: m = off[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    function automatic logic [31:0] replicate_store(input size_e sz, input logic [31:0] d);
        logic [31:0] r;
        case (sz)
            SZ_BYTE: r = {4{d[7:0]}};
            SZ_HALF: r = {2{d[15:0]}};
            default: r = d;
        endcase
        return r;
    endfunction

    logic [31:0]   mem_q [DEPTH_WORDS];
    logic [31:0]   gpio_q, gpio_d;
    logic [31:0]   cycle_q, cycle_d;
    logic          misalign_q, misalign_d;

    size_e         size;
    logic          sext;
    logic          misaligned;
    logic          access_ok;
    region_e       region;
    logic [AW-1:0] ram_idx;
    logic [31:0]   raw_word;
    logic [31:0]   lane_word;
    logic          store_ok;
    logic          ram_we;
    logic [3:0]    ram_be;
    logic [31:0]   ram_wdata;

    always_comb begin
        size = SZ_ILL;
        sext = 1'b0;
        case (funct3)
            3'b000: begin size = SZ_BYTE; sext = 1'b1; end
            3'b001: begin size = SZ_HALF; sext = 1'b1; end
            3'b010: begin size = SZ_WORD; sext = 1'b0; end
            3'b100: begin size = SZ_BYTE; sext = 1'b0; end
            3'b101: begin size = SZ_HALF; sext = 1'b0; end
            default: begin size = SZ_ILL; sext = 1'b0; end
        endcase
    end

    // Illegal encodings never count as misaligned, so they cannot set STATUS.
    assign misaligned = ((size == SZ_HALF) && Mem_WrAddr[0]) ||
                        ((size == SZ_WORD) && (Mem_WrAddr[1:0] != 2'b00));
    assign access_ok  = (size != SZ_ILL) && !misaligned;

    // MMIO registers decode on the word address, so a misaligned hit still lands on them.
    always_comb begin
        region = RG_NONE;
        if (Mem_WrAddr < MMIO_BASE) begin
            region = RG_RAM;
        end else if (Mem_WrAddr[31:2] == BASE_W) begin
            region = RG_GPIO;
        end else if (Mem_WrAddr[31:2] == BASE_W + 30'd1) begin
            region = RG_CYCLE;
        end else if (Mem_WrAddr[31:2] == BASE_W + 30'd2) begin
            region = RG_STATUS;
        end
    end

    assign ram_idx = Mem_WrAddr[AW+1:2];

    always_comb begin
        raw_word = 32'd0;
        case (region)
            RG_RAM:    raw_word = mem_q[ram_idx];
            RG_GPIO:   raw_word = gpio_q;
            RG_CYCLE:  raw_word = cycle_q;
            RG_STATUS: raw_word = {31'd0, misalign_q};
            default:   raw_word = 32'd0;
        endcase
    end

    assign lane_word = raw_word >> {Mem_WrAddr[1:0], 3'b000};
    assign ReadData  = access_ok ? extend_load(lane_word, size, sext) : 32'd0;

    assign store_ok  = MemWrite && access_ok && !reset;
    assign ram_we    = store_ok && (region == RG_RAM);
    assign ram_be    = lane_mask(size, Mem_WrAddr[1:0]);
    assign ram_wdata = replicate_store(size, Mem_WrData);

    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (ram_be[i]) begin
                    mem_q[ram_idx][8*i +: 8] <= ram_wdata[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        gpio_d     = gpio_q;
        cycle_d    = cycle_q + 32'd1;
        misalign_d = misalign_q;
        if (store_ok) begin
            case (region)
                RG_GPIO:   gpio_d  = Mem_WrData;
                RG_CYCLE:  cycle_d = Mem_WrData;
                RG_STATUS: if (Mem_WrData[0]) misalign_d = 1'b0;
                default:   ;
            endcase
        end
        // A new fault outranks a clear issued in the same cycle.
        if ((MemRead || MemWrite) && misaligned) begin
            misalign_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            gpio_q     <= 32'd0;
            cycle_q    <= 32'd0;
            misalign_q <= 1'b0;
        end else begin
            gpio_q     <= gpio_d;
            cycle_q    <= cycle_d;
            misalign_q <= misalign_d;
        end
    end

    assign gpio_out = gpio_q;
    assign err_irq  = misalign_q;

endmodule

// File: doc/riscv_dmem_resp.md
# riscv_dmem_resp

Data-memory responder for the single-cycle `riscv_cpu`. It sits on the far side of the CPU's data port and services `MemWrite`/`Mem_WrAddr`/`Mem_WrData`/`ReadData`.

- Provides a word-organised RAM with byte, halfword and word stores.
- Returns sign- or zero-extended loads.
- Decodes a small MMIO page holding a GPIO output register, a free-running cycle counter and a sticky misalignment status.
- Reads are combinational so the single-cycle datapath closes. All state changes occur on the rising clock edge.

## Interface

Parameters:
- `DEPTH_WORDS`, default 64: RAM depth in 32-bit words. Must be a power of two.
- `MMIO_BASE`, default 32'h0000_1000: base address of the MMIO page.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high.
- `MemWrite` input 1: store strobe for the current instruction.
- `MemRead` input 1: load strobe for the current instruction.
- `funct3` input 3: access size and sign (instr[14:12]).
- `Mem_WrAddr` input 32: byte address (ALU result) for loads and stores.
- `Mem_WrData` input 32: store data, right-aligned (rs2).
- `ReadData` output 32: load result, already extended.
- `gpio_out` output 32: GPIO output register.
- `err_irq` output 1: level copy of the sticky misalignment flag.

## Operation

Address decode:
- RAM region: `Mem_WrAddr < MMIO_BASE`. Word index is `Mem_WrAddr[log2(DEPTH_WORDS)+1:2]`, so addresses alias modulo the RAM size.
- `MMIO_BASE+0`: GPIO register, read/write.
- `MMIO_BASE+4`: CYCLE counter. Reads return the current count. A write loads the counter.
- `MMIO_BASE+8`: STATUS. Bit0 is MISALIGN, cleared by writing 1 (W1C). Bits 31:1 read 0.
- Any other address: reads return 0; writes are ignored.

`funct3` size and extension:
- 000 LB/SB: byte, sign-extend on load.
- 001 LH/SH: halfword, sign-extend on load.
- 010 LW/SW: word.
- 100 LBU: byte, zero-extend.
- 101 LHU: halfword, zero-extend.
- 011, 110, 111 are illegal: a store is dropped and a load returns 0. Illegal encodings do not set MISALIGN.

Alignment:
- A halfword access with `addr[0]=1` is misaligned.
- A word access with `addr[1:0]!=0` is misaligned.
- On a misaligned access with `MemRead` or `MemWrite` high:
  - a store writes nothing;
  - a load returns 0;
  - MISALIGN is set at the next edge.

Stores:
- Byte lanes are selected by `addr[1:0]`.
- SB writes `Mem_WrData[7:0]` into lane `addr[1:0]`.
- SH writes `Mem_WrData[15:0]` into lanes `{addr[1],0}` and `{addr[1],1}`.
- Untouched lanes keep their value.
- MMIO registers are always written as a full word, ignoring size, but the alignment check still applies.

Loads:
- `ReadData` is combinational from the address, `funct3` and current state.
- The extracted lane is shifted to bit 0, then extended.
- When `MemRead=0`, `ReadData` is still driven with the decoded value. No state changes.

CYCLE:
- Increments by 1 every cycle and wraps from 32'hFFFF_FFFF to 0.
- A write in cycle N makes the counter equal to `Mem_WrData` after edge N; it counts from there.

STATUS:
- If a set (misaligned access) and a W1C clear of MISALIGN happen in the same cycle, set wins.
- A misaligned write to STATUS sets MISALIGN and does not clear it.

## Timing

- Reset values after the reset edge:
  - `gpio_out` = 0;
  - CYCLE = 0;
  - MISALIGN = 0, so `err_irq` = 0;
  - `ReadData` follows the decode of the current inputs.
  - RAM contents are not reset and are retained across reset.
- While `reset` is high, all stores and CYCLE increments are suppressed.
- Reset asserted in the same cycle as a store: the store is dropped.
- Store latency: a store in cycle N is visible to a load in cycle N+1. In cycle N, `ReadData` still shows the old data; there is no write-through bypass.
- Load latency: 0 cycles (combinational).
- CYCLE read in cycle N returns the pre-edge value; the first cycle after reset reads 0.
- `err_irq` rises one cycle after the offending access and stays high until cleared by W1C or reset.

## Test plan

- Reset, then SW 32'hDEADBEEF to 0x10, then LW 0x10 → 32'hDEADBEEF.
  - LB 0x13 → 32'hFFFFFFDE.
  - LBU 0x13 → 32'h000000DE.
  - LH 0x12 → 32'hFFFFDEAD.
  - LHU 0x10 → 32'h0000BEEF.
- Over that word, SB 32'h55 to 0x11, then LW 0x10 → 32'hDEAD55EF. Then SH 32'h1234 to 0x12, then LW 0x10 → 32'h123455EF.
- SW 32'hCAFEF00D to 0x14, then LW 0x14 with `DEPTH_WORDS`=64 → 32'hCAFEF00D, and LW 0x114 → 32'hCAFEF00D (alias).
- Misalignment:
  - SW to 0x22 → RAM word 0x20 unchanged, and `err_irq`=1 on the next cycle.
  - LW 0x1008 → 1.
  - SW 1 to 0x1008 → `err_irq`=0 the next cycle.
  - A simultaneous misaligned access plus clear leaves `err_irq`=1.
- GPIO: SW 32'hA5A5_0F0F to 0x1000 → `gpio_out`=32'hA5A50F0F on the next cycle. Assert reset → `gpio_out`=0 after the edge, while RAM word 0x10 still holds its prior value.
- CYCLE: after reset, LW 0x1004 on consecutive cycles returns 0, 1, 2. Then:
  - SW 32'hFFFF_FFFE to 0x1004, then reads on the following cycles → FFFFFFFE, FFFFFFFF, 0 (wrap).
  - A write to an unmapped address 0x100C has no effect, and a load from it returns 0.
